sync_fifo_param: RTL and testbench
==================================

Name: sync_fifo_param

Overview:
Parametrised synchronous FIFO with independent write/read enables, full/empty and programmable almost-full/almost-empty flags, occupancy count, sticky overflow/underflow error flags and a synchronous flush. It generalises the team's fixed 8-deep, 1-bit shift-register FIFO to arbitrary width and depth. It uses a circular buffer with read/write pointers, not shifting. It sits between a producer and a consumer in the same clock domain, such as a serial front-end and a downstream byte processor.

Parameters:
WIDTH, 8, data word width in bits (>=1)
DEPTH, 8, number of entries; power of two, >=2
AF_LEVEL, DEPTH-1, almost_full asserts when count >= AF_LEVEL
AE_LEVEL, 1, almost_empty asserts when count <= AE_LEVEL

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
clr  input  1  synchronous flush; empties FIFO, keeps error flags
wr_en  input  1  write request
datain  input  WIDTH  write data, sampled when wr_en accepted
rd_en  input  1  read request
dataout  output  WIDTH  read data, registered
dout_valid  output  1  dataout holds a newly popped word this cycle
full  output  1  count == DEPTH
empty  output  1  count == 0
almost_full  output  1  count >= AF_LEVEL
almost_empty  output  1  count <= AE_LEVEL
count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
overflow  output  1  sticky: a write was rejected
underflow  output  1  sticky: a read was rejected

Behaviour:
- Reset (rst=1, asynchronous): pointers=0, count=0, dataout=0, dout_valid=0, overflow=0, underflow=0. Flags are therefore empty=1, full=0, almost_empty=1, almost_full=(AF_LEVEL==0). Memory contents are not reset.
- Pointers: wr_ptr and rd_ptr are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0. Occupancy is tracked by a separate count register.
- Read acceptance: rd_ok = rd_en & ~empty.
- Write acceptance: wr_ok = wr_en & (~full | rd_ok). A write to a full FIFO is accepted only if a read is accepted in the same cycle.
- Write effect: on wr_ok, mem[wr_ptr] <= datain and wr_ptr++.
- Read effect: on rd_ok, dataout <= mem[rd_ptr], rd_ptr++, and dout_valid=1 next cycle. Otherwise dout_valid=0 and dataout holds its previous value. Read latency is 1 cycle.
- Count update: count += wr_ok - rd_ok. Simultaneous accepted read and write leaves count unchanged.
- Empty-cycle read with write: no fall-through. When empty, rd_en with wr_en rejects the read (underflow=1) and accepts the write. The word becomes readable the next cycle.
- Error flags: overflow <= 1 on wr_en & ~wr_ok; underflow <= 1 on rd_en & ~rd_ok. Both are sticky and cleared only by rst.
- Flag timing: full, empty, almost_full, almost_empty and count are registered or derived combinationally from registered count. They reflect the post-update state one cycle after the causing edge.
- clr: on the clock edge, pointers=0, count=0, dout_valid=0. wr_en and rd_en in that cycle are ignored and raise no error flags. dataout holds its value.
- rst mid-operation: takes effect immediately regardless of clk. All in-flight data is discarded.
- Parameter checks: elaboration must fail if DEPTH is not a power of two, or if AF_LEVEL>DEPTH or AE_LEVEL>DEPTH.

Test Plan:
- Bench configuration for all cases: WIDTH=8, DEPTH=4, defaults otherwise.
- Reset then idle -> empty=1, full=0, count=0, dout_valid=0, dataout=0, overflow=underflow=0.
- Write 0x11,0x22,0x33,0x44 on consecutive cycles -> count 1,2,3,4; almost_full=1 at count 3; full=1 at 4. A fifth write of 0x55 leaves count=4 and sets overflow=1.
- Read the full FIFO four cycles -> dataout 0x11,0x22,0x33,0x44, each with dout_valid=1 one cycle after its rd_en; empty=1 after the last. A further rd_en sets underflow=1 and gives dout_valid=0.
- When full, simultaneous wr_en(0xAA) and rd_en -> count stays 4, no overflow. 0xAA is returned after three more reads (pointer wrap check).
- When empty, simultaneous wr_en(0x5A) and rd_en -> underflow=1, count=1. The next-cycle read returns 0x5A.
- Load 3 words, assert clr with wr_en=1 -> count=0, empty=1, overflow unchanged. Assert rst asynchronously mid-write -> all outputs return to reset values before the next clk edge.

Source files
------------

// File: rtl/sync_fifo_param_if.sv
// Producer/consumer bundle for sync_fifo_param; the FIFO takes the slave side.
// count is wide enough to hold 0..DEPTH inclusive.
interface sync_fifo_param_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             clr;
    logic             wr_en;
    logic [WIDTH-1:0] datain;
    logic             rd_en;
    logic [WIDTH-1:0] dataout;
    logic             dout_valid;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic [CW-1:0]    count;
    logic             overflow;
    logic             underflow;

    modport master (
        output clr, wr_en, datain, rd_en,
        input  dataout, dout_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  clr, wr_en, datain, rd_en,
        output dataout, dout_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_param.sv
// Circular-buffer synchronous FIFO; registered read data one cycle after an accepted rd_en.
// No fall-through; writes to a full FIFO pass only alongside an accepted read, rejects set sticky errors.
module sync_fifo_param #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = DEPTH - 1,
    parameter int AE_LEVEL = 1
) (
    input  logic             clk,
    input  logic             rst,
    sync_fifo_param_if.slave fifo_if
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_CNT   = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_CNT   = CW'(AE_LEVEL);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("sync_fifo_param: DEPTH must be a power of two >= 2");
    end
    if ((AF_LEVEL > DEPTH) || (AE_LEVEL > DEPTH)) begin : g_bad_levels
        $error("sync_fifo_param: AF_LEVEL and AE_LEVEL must not exceed DEPTH");
    end
    if (WIDTH < 1) begin : g_bad_width
        $error("sync_fifo_param: WIDTH must be >= 1");
    end

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] dataout_q, dataout_d;
    logic             dout_valid_q, dout_valid_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;

    logic             full;
    logic             empty;
    logic             rd_ok;
    logic             wr_ok;

    always_comb begin
        empty = (count_q == '0);
        full  = (count_q == FULL_CNT);
        // A flush swallows both requests, so neither can be accepted nor flagged.
        rd_ok = fifo_if.rd_en & ~empty & ~fifo_if.clr;
        wr_ok = fifo_if.wr_en & (~full | rd_ok) & ~fifo_if.clr;
    end

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        dataout_d    = dataout_q;
        dout_valid_d = 1'b0;
        overflow_d   = overflow_q;
        underflow_d  = underflow_q;

        if (fifo_if.clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_ok) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (rd_ok) begin
                rd_ptr_d     = rd_ptr_q + 1'b1;
                dataout_d    = mem_q[rd_ptr_q];
                dout_valid_d = 1'b1;
            end
            case ({wr_ok, rd_ok})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
            if (fifo_if.wr_en && !wr_ok) begin
                overflow_d = 1'b1;
            end
            if (fifo_if.rd_en && !rd_ok) begin
                underflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            dataout_q    <= '0;
            dout_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            dataout_q    <= dataout_d;
            dout_valid_q <= dout_valid_d;
            overflow_q   <= overflow_d;
            underflow_q  <= underflow_d;
        end
    end

    // Storage is deliberately left out of reset; only words behind count are ever read.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_q[wr_ptr_q] <= fifo_if.datain;
        end
    end

    assign fifo_if.dataout      = dataout_q;
    assign fifo_if.dout_valid   = dout_valid_q;
    assign fifo_if.full         = full;
    assign fifo_if.empty        = empty;
    assign fifo_if.almost_full  = (count_q >= AF_CNT);
    assign fifo_if.almost_empty = (count_q <= AE_CNT);
    assign fifo_if.count        = count_q;
    assign fifo_if.overflow     = overflow_q;
    assign fifo_if.underflow    = underflow_q;
endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param (WIDTH=8, DEPTH=4): directed scenarios plus random traffic
// against a queue-based reference model.
module tb_sync_fifo_param;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int CW    = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    sync_fifo_param_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut_if ();

    sync_fifo_param #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .fifo_if (dut_if.slave)
    );

    int vec  = 0;
    int errs = 0;

    logic [7:0] q[$];
    logic [7:0] m_dout;
    logic       m_dv, m_ovf, m_unf;

    // {full, empty, almost_full, almost_empty, dout_valid, overflow, underflow, count, dataout}
    function automatic logic [17:0] status();
        return {dut_if.full, dut_if.empty, dut_if.almost_full, dut_if.almost_empty,
                dut_if.dout_valid, dut_if.overflow, dut_if.underflow,
                dut_if.count, dut_if.dataout};
    endfunction

    function automatic logic [17:0] exp_status();
        int n;
        n = q.size();
        return {n == DEPTH, n == 0, n >= DEPTH - 1, n <= 1,
                m_dv, m_ovf, m_unf, 3'(n), m_dout};
    endfunction

    task automatic model_reset();
        q.delete();
        m_dout = '0;
        m_dv   = 1'b0;
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
    endtask

    // Apply one cycle of requests, advance the model across the edge, return 1ns after it.
    task automatic cyc(input logic wr, input logic [7:0] din, input logic rd, input logic cl);
        bit rok, wok;
        dut_if.wr_en  = wr;
        dut_if.datain = din;
        dut_if.rd_en  = rd;
        dut_if.clr    = cl;
        @(posedge clk);
        rok = rd && (q.size() != 0);
        wok = wr && ((q.size() < DEPTH) || rok);
        if (cl) begin
            q.delete();
            m_dv = 1'b0;
        end else begin
            m_dv = rok;
            if (rok) m_dout = q.pop_front();
            if (wok) q.push_back(din);
            if (wr && !wok) m_ovf = 1'b1;
            if (rd && !rok) m_unf = 1'b1;
        end
        #1;
    endtask

    task automatic do_reset();
        dut_if.wr_en  = 1'b0;
        dut_if.datain = '0;
        dut_if.rd_en  = 1'b0;
        dut_if.clr    = 1'b0;
        #2 rst = 1'b1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        cyc(0, 8'h00, 0, 0);
        vec++;
        if (status() !== {1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00}) begin
            errs++;
            $display("FAIL reset_status: got %h want %h", status(),
                     {1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00});
        end
    endtask

    task automatic test_fill_drain();
        logic [7:0] d [4];
        d = '{8'h11, 8'h22, 8'h33, 8'h44};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cyc(1, d[i], 0, 0);
            vec++;
            if (dut_if.count !== 3'(i + 1)) begin
                errs++;
                $display("FAIL fill_count[%0d]: got %0d want %0d", i, dut_if.count, i + 1);
            end
            vec++;
            if ({dut_if.almost_full, dut_if.full} !== {i >= 2, i == 3}) begin
                errs++;
                $display("FAIL fill_flags[%0d]: got af/full %b%b want %b%b", i,
                         dut_if.almost_full, dut_if.full, i >= 2, i == 3);
            end
        end
        cyc(1, 8'h55, 0, 0);
        vec++;
        if ({dut_if.count, dut_if.overflow} !== {3'd4, 1'b1}) begin
            errs++;
            $display("FAIL overflow_write: got count=%0d ovf=%b want count=4 ovf=1",
                     dut_if.count, dut_if.overflow);
        end
        for (int i = 0; i < 4; i++) begin
            cyc(0, 8'h00, 1, 0);
            vec++;
            if ({dut_if.dout_valid, dut_if.dataout} !== {1'b1, d[i]}) begin
                errs++;
                $display("FAIL drain[%0d]: got dv=%b data=%h want dv=1 data=%h", i,
                         dut_if.dout_valid, dut_if.dataout, d[i]);
            end
        end
        vec++;
        if (dut_if.empty !== 1'b1) begin
            errs++;
            $display("FAIL drain_empty: got %b want 1", dut_if.empty);
        end
        cyc(0, 8'h00, 1, 0);
        vec++;
        if ({dut_if.underflow, dut_if.dout_valid} !== 2'b10) begin
            errs++;
            $display("FAIL underflow_read: got unf=%b dv=%b want unf=1 dv=0",
                     dut_if.underflow, dut_if.dout_valid);
        end
    endtask

    task automatic test_full_rw();
        logic [7:0] w [4];
        do_reset();
        for (int i = 0; i < 4; i++) begin
            w[i] = 8'($urandom);
            cyc(1, w[i], 0, 0);
        end
        cyc(1, 8'hAA, 1, 0);
        vec++;
        if ({dut_if.count, dut_if.overflow, dut_if.dout_valid, dut_if.dataout} !==
            {3'd4, 1'b0, 1'b1, w[0]}) begin
            errs++;
            $display("FAIL full_rw: got count=%0d ovf=%b dv=%b data=%h want 4 0 1 %h",
                     dut_if.count, dut_if.overflow, dut_if.dout_valid, dut_if.dataout, w[0]);
        end
        for (int i = 1; i < 4; i++) begin
            cyc(0, 8'h00, 1, 0);
            vec++;
            if (dut_if.dataout !== w[i]) begin
                errs++;
                $display("FAIL full_rw_read[%0d]: got %h want %h", i, dut_if.dataout, w[i]);
            end
        end
        cyc(0, 8'h00, 1, 0);
        vec++;
        if ({dut_if.dout_valid, dut_if.dataout, dut_if.empty} !== {1'b1, 8'hAA, 1'b1}) begin
            errs++;
            $display("FAIL wrap_read: got dv=%b data=%h empty=%b want 1 aa 1",
                     dut_if.dout_valid, dut_if.dataout, dut_if.empty);
        end
    endtask

    task automatic test_empty_rw();
        do_reset();
        cyc(1, 8'h5A, 1, 0);
        vec++;
        if ({dut_if.underflow, dut_if.count, dut_if.dout_valid} !== {1'b1, 3'd1, 1'b0}) begin
            errs++;
            $display("FAIL empty_rw: got unf=%b count=%0d dv=%b want 1 1 0",
                     dut_if.underflow, dut_if.count, dut_if.dout_valid);
        end
        cyc(0, 8'h00, 1, 0);
        vec++;
        if ({dut_if.dout_valid, dut_if.dataout} !== {1'b1, 8'h5A}) begin
            errs++;
            $display("FAIL empty_rw_read: got dv=%b data=%h want 1 5a",
                     dut_if.dout_valid, dut_if.dataout);
        end
    endtask

    task automatic test_clr();
        do_reset();
        for (int i = 0; i < 5; i++) cyc(1, 8'(8'hC0 + i), 0, 0);
        cyc(0, 8'h00, 1, 0);
        cyc(1, 8'h77, 1, 1);
        vec++;
        if ({dut_if.count, dut_if.empty, dut_if.overflow, dut_if.underflow,
             dut_if.dout_valid, dut_if.dataout} !== {3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'hC0}) begin
            errs++;
            $display("FAIL clr: got count=%0d empty=%b ovf=%b unf=%b dv=%b data=%h want 0 1 1 0 0 c0",
                     dut_if.count, dut_if.empty, dut_if.overflow, dut_if.underflow,
                     dut_if.dout_valid, dut_if.dataout);
        end
        cyc(0, 8'h00, 1, 0);
        vec++;
        if ({dut_if.underflow, dut_if.dout_valid} !== 2'b10) begin
            errs++;
            $display("FAIL clr_then_read: got unf=%b dv=%b want 1 0",
                     dut_if.underflow, dut_if.dout_valid);
        end
        cyc(1, 8'h3C, 0, 0);
        cyc(0, 8'h00, 1, 0);
        vec++;
        if ({dut_if.dout_valid, dut_if.dataout} !== {1'b1, 8'h3C}) begin
            errs++;
            $display("FAIL clr_reuse: got dv=%b data=%h want 1 3c",
                     dut_if.dout_valid, dut_if.dataout);
        end
    endtask

    task automatic test_async_rst();
        do_reset();
        cyc(1, 8'hA1, 0, 0);
        cyc(1, 8'hA2, 0, 0);
        cyc(1, 8'hA3, 1, 0);
        #2 rst = 1'b1;
        #1;
        vec++;
        if (status() !== {1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00}) begin
            errs++;
            $display("FAIL async_rst: got %h want %h", status(),
                     {1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00});
        end
        model_reset();
        dut_if.wr_en = 1'b0;
        dut_if.rd_en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_random();
        int pw, pr;
        logic wr, rd, cl;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            case ((n / 40) % 3)
                0:       begin pw = 80; pr = 25; end
                1:       begin pw = 25; pr = 80; end
                default: begin pw = 60; pr = 60; end
            endcase
            wr = ($urandom_range(99) < pw);
            rd = ($urandom_range(99) < pr);
            cl = ($urandom_range(63) == 0);
            cyc(wr, 8'($urandom), rd, cl);
            vec++;
            if (status() !== exp_status()) begin
                errs++;
                $display("FAIL random[%0d]: got %h want %h (wr=%b rd=%b clr=%b)",
                         n, status(), exp_status(), wr, rd, cl);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_full_rw();
        test_empty_rw();
        test_clr();
        test_async_rst();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete, %0d vectors applied", vec);
        $fatal(1, "timeout");
    end
endmodule
